// File: rtl/idct_pkg.sv
// Shared constants, FSM encoding and the fixed-point cosine table for the
// 8-point one-dimensional inverse DCT.
package idct_pkg;

  localparam int DEF_IN_WORD_SIZE  = 15;
  localparam int DEF_OUT_WORD_SIZE = 8;
  localparam int DEF_COEF_FRAC     = 12;
  localparam int ACC_W             = 32;
  localparam int COEF_W            = 13;
  localparam int N_PTS             = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // COEF_TABLE[n][k] = round(4096 * c(k)/2 * cos((2n+1)k*pi/16)); row = output
  // position n, column = input frequency k.
  localparam logic signed [COEF_W-1:0] COEF_TABLE [N_PTS][N_PTS] = '{
    '{13'sd1448,  13'sd2009,  13'sd1892,  13'sd1703,  13'sd1448,  13'sd1138,  13'sd784,   13'sd400},
    '{13'sd1448,  13'sd1703,  13'sd784,  -13'sd400,  -13'sd1448, -13'sd2009, -13'sd1892, -13'sd1138},
    '{13'sd1448,  13'sd1138, -13'sd784,  -13'sd2009, -13'sd1448,  13'sd400,   13'sd1892,  13'sd1703},
    '{13'sd1448,  13'sd400,  -13'sd1892, -13'sd1138,  13'sd1448,  13'sd1703, -13'sd784,  -13'sd2009},
    '{13'sd1448, -13'sd400,  -13'sd1892,  13'sd1138,  13'sd1448, -13'sd1703, -13'sd784,   13'sd2009},
    '{13'sd1448, -13'sd1138, -13'sd784,   13'sd2009, -13'sd1448, -13'sd400,   13'sd1892, -13'sd1703},
    '{13'sd1448, -13'sd1703,  13'sd784,   13'sd400,  -13'sd1448,  13'sd2009, -13'sd1892,  13'sd1138},
    '{13'sd1448, -13'sd2009,  13'sd1892, -13'sd1703,  13'sd1448, -13'sd1138,  13'sd784,  -13'sd400}
  };

endpackage

// File: rtl/idct_coef_rom.sv
// Combinational column lookup: for frequency k, return C[0..7][k] packed with
// lane n in bits [n*COEF_W +: COEF_W].
module idct_coef_rom
  import idct_pkg::*;
(
  input  logic [2:0]              i_k,
  output logic [N_PTS*COEF_W-1:0] o_col
);

  genvar gi;
  generate
    for (gi = 0; gi < N_PTS; gi++) begin : g_row
      assign o_col[gi*COEF_W +: COEF_W] = COEF_TABLE[gi][i_k];
    end
  endgenerate

endmodule

// File: rtl/idct_1d.sv
// 8-point 1-D IDCT: a captured coefficient vector is walked one frequency per
// cycle through eight parallel multiply-accumulate lanes, then each lane is
// rounded, clamped to 0..255 and held until the next result.
module idct_1d
  import idct_pkg::*;
#(
  parameter int IN_WORD_SIZE  = DEF_IN_WORD_SIZE,
  parameter int OUT_WORD_SIZE = DEF_OUT_WORD_SIZE,
  parameter int COEF_FRAC     = DEF_COEF_FRAC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_WORD_SIZE-1:0]  z0,
  input  logic [IN_WORD_SIZE-1:0]  z1,
  input  logic [IN_WORD_SIZE-1:0]  z2,
  input  logic [IN_WORD_SIZE-1:0]  z3,
  input  logic [IN_WORD_SIZE-1:0]  z4,
  input  logic [IN_WORD_SIZE-1:0]  z5,
  input  logic [IN_WORD_SIZE-1:0]  z6,
  input  logic [IN_WORD_SIZE-1:0]  z7,
  output logic                     out_valid,
  output logic [OUT_WORD_SIZE-1:0] x0,
  output logic [OUT_WORD_SIZE-1:0] x1,
  output logic [OUT_WORD_SIZE-1:0] x2,
  output logic [OUT_WORD_SIZE-1:0] x3,
  output logic [OUT_WORD_SIZE-1:0] x4,
  output logic [OUT_WORD_SIZE-1:0] x5,
  output logic [OUT_WORD_SIZE-1:0] x6,
  output logic [OUT_WORD_SIZE-1:0] x7
);

  localparam logic signed [ACC_W-1:0] RND_ADD = ACC_W'(1) <<< (COEF_FRAC - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) <<< OUT_WORD_SIZE) - ACC_W'(1);

  state_t                          r_state;
  state_t                          w_state_next;
  logic [2:0]                      r_cnt;
  logic                            w_accept;
  logic                            w_last;
  logic [IN_WORD_SIZE-1:0]         w_z_in [N_PTS];
  logic signed [IN_WORD_SIZE-1:0]  r_z    [N_PTS];
  logic signed [IN_WORD_SIZE-1:0]  w_zk;
  logic [N_PTS*COEF_W-1:0]         w_col;

  assign w_z_in[0] = z0;
  assign w_z_in[1] = z1;
  assign w_z_in[2] = z2;
  assign w_z_in[3] = z3;
  assign w_z_in[4] = z4;
  assign w_z_in[5] = z5;
  assign w_z_in[6] = z6;
  assign w_z_in[7] = z7;

  // Ready is forced low while reset is held so nothing is accepted in reset.
  assign in_ready  = rst && (r_state != MAC);
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_state == MAC) && (r_cnt == 3'd7);
  assign out_valid = (r_state == DONE);
  assign w_zk      = r_z[r_cnt];

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  // Next-state logic: a vector accepted in DONE goes straight back into MAC.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_next = MAC;
      MAC:     if (r_cnt == 3'd7) w_state_next = DONE;
      DONE:    w_state_next = w_accept ? MAC : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Frequency counter: restarts on acceptance, steps once per MAC cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                r_cnt <= 3'd0;
    else if (w_accept)       r_cnt <= 3'd0;
    else if (r_state == MAC) r_cnt <= r_cnt + 3'd1;
  end

  // Coefficient capture; later input changes are ignored until the next acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_PTS; i++) r_z[i] <= '0;
    end else if (w_accept) begin
      for (int i = 0; i < N_PTS; i++) r_z[i] <= w_z_in[i];
    end
  end

  idct_coef_rom u_coef_rom (
    .i_k   (r_cnt),
    .o_col (w_col)
  );

  genvar gi;
  generate
    for (gi = 0; gi < N_PTS; gi++) begin : g_lane
      logic signed [COEF_W-1:0]        w_coef;
      logic signed [ACC_W-1:0]         w_prod;
      logic signed [ACC_W-1:0]         w_sum;
      logic signed [ACC_W-1:0]         w_rnd;
      logic signed [ACC_W-1:0]         r_acc;
      logic [OUT_WORD_SIZE-1:0]        r_x;

      assign w_coef = w_col[gi*COEF_W +: COEF_W];
      assign w_prod = ACC_W'(w_zk) * ACC_W'(w_coef);
      assign w_sum  = r_acc + w_prod;
      assign w_rnd  = (w_sum + RND_ADD) >>> COEF_FRAC;

      // Accumulator: cleared on acceptance, one product added per MAC cycle.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)                r_acc <= '0;
        else if (w_accept)       r_acc <= '0;
        else if (r_state == MAC) r_acc <= w_sum;
      end

      // Output sample: rounded and clamped from the final sum on the MAC->DONE edge.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_x <= '0;
        end else if (w_last) begin
          if (w_rnd < 0)             r_x <= '0;
          else if (w_rnd > SAT_MAX)  r_x <= '1;
          else                       r_x <= w_rnd[OUT_WORD_SIZE-1:0];
        end
      end
    end
  endgenerate

  assign x0 = g_lane[0].r_x;
  assign x1 = g_lane[1].r_x;
  assign x2 = g_lane[2].r_x;
  assign x3 = g_lane[3].r_x;
  assign x4 = g_lane[4].r_x;
  assign x5 = g_lane[5].r_x;
  assign x6 = g_lane[6].r_x;
  assign x7 = g_lane[7].r_x;

endmodule

// File: tb/tb_idct_1d.sv
// Self-checking bench for idct_1d against a floating-point cosine model.
module tb_idct_1d;

  // Edges from the acceptance edge to the edge where out_valid is first seen
  // high: eight MAC cycles, DONE entered on the eighth (ninth edge counting
  // the acceptance edge itself).
  localparam int LAT_EDGES = 8;
  localparam real PI = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic [14:0] z0, z1, z2, z3, z4, z5, z6, z7;
  logic [7:0]  x0, x1, x2, x3, x4, x5, x6, x7;
  logic [7:0]  xs [8];

  int checks = 0;
  int errors = 0;
  int cmat [8][8];
  int zv   [8];
  int expx [8];
  int got  [8];
  int lat;

  idct_1d dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .z0(z0), .z1(z1), .z2(z2), .z3(z3), .z4(z4), .z5(z5), .z6(z6), .z7(z7),
    .out_valid(out_valid),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3), .x4(x4), .x5(x5), .x6(x6), .x7(x7)
  );

  assign xs[0] = x0; assign xs[1] = x1; assign xs[2] = x2; assign xs[3] = x3;
  assign xs[4] = x4; assign xs[5] = x5; assign xs[6] = x6; assign xs[7] = x7;

  always #5 clk = ~clk;

  function automatic int round_real(input real v);
    if (v >= 0.0) return $rtoi($floor(v + 0.5));
    return -$rtoi($floor(-v + 0.5));
  endfunction

  // Coefficients straight from the cosine definition.
  task automatic build_coefs();
    for (int n = 0; n < 8; n++)
      for (int k = 0; k < 8; k++) begin
        real ck;
        ck = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
        cmat[n][k] = round_real(4096.0 * ck / 2.0 * $cos((2 * n + 1) * k * PI / 16.0));
      end
  endtask

  // Expected samples for zv: exact integer dot product, round half up, clamp.
  task automatic compute_expected();
    for (int n = 0; n < 8; n++) begin
      longint acc;
      real    q;
      acc = 0;
      for (int k = 0; k < 8; k++) acc += longint'(zv[k]) * longint'(cmat[n][k]);
      q = $floor((real'(acc) + 2048.0) / 4096.0);
      if (q < 0.0)        expx[n] = 0;
      else if (q > 255.0) expx[n] = 255;
      else                expx[n] = $rtoi(q);
    end
  endtask

  task automatic drive_z();
    z0 = 15'(zv[0]); z1 = 15'(zv[1]); z2 = 15'(zv[2]); z3 = 15'(zv[3]);
    z4 = 15'(zv[4]); z5 = 15'(zv[5]); z6 = 15'(zv[6]); z7 = 15'(zv[7]);
  endtask

  task automatic scramble_z();
    for (int k = 0; k < 8; k++) zv[k] = int'($urandom_range(0, 32767)) - 16384;
    drive_z();
  endtask

  // Present zv, wait for acceptance, then count edges until out_valid (-1 on timeout).
  task automatic run_vector();
    drive_z();
    in_valid = 1'b1;
    for (int w = 0; w < 20 && !in_ready; w++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 30) begin @(posedge clk); #1; lat++; end
    if (!out_valid) lat = -1;
    for (int i = 0; i < 8; i++) got[i] = int'(xs[i]);
  endtask

  task automatic test_reset();
    bit bad;
    rst = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 8; k++) zv[k] = 0;
    drive_z();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    bad = 0;
    for (int i = 0; i < 8; i++) if (xs[i] !== 8'd0) bad = 1;
    checks++;
    if (bad) begin errors++; $display("FAIL reset_x got=%0d,%0d,%0d,%0d want=0", x0, x1, x2, x3); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got=%b want=1", in_ready); end
    $display("reset: in_ready=%b out_valid=%b", in_ready, out_valid);
  endtask

  task automatic test_dc();
    bit bad;
    zv[0] = 283;
    for (int k = 1; k < 8; k++) zv[k] = 0;
    run_vector();
    checks++;
    if (lat !== LAT_EDGES) begin errors++; $display("FAIL dc_latency got=%0d want=%0d", lat, LAT_EDGES); end
    bad = 0;
    for (int i = 0; i < 8; i++) if (got[i] != 100) bad = 1;
    checks++;
    if (bad) begin errors++; $display("FAIL dc_x got=%0d %0d %0d %0d %0d %0d %0d %0d want=100", got[0], got[1], got[2], got[3], got[4], got[5], got[6], got[7]); end
    $display("dc: lat=%0d x0=%0d x7=%0d", lat, got[0], got[7]);
  endtask

  task automatic test_saturation();
    int want [2];
    int z0v  [2];
    bit bad;
    z0v[0] = 16383; want[0] = 255;
    z0v[1] = -100;  want[1] = 0;
    for (int t = 0; t < 2; t++) begin
      zv[0] = z0v[t];
      for (int k = 1; k < 8; k++) zv[k] = 0;
      run_vector();
      bad = (lat != LAT_EDGES);
      for (int i = 0; i < 8; i++) if (got[i] != want[t]) bad = 1;
      checks++;
      if (bad) begin errors++; $display("FAIL saturation z0=%0d got=%0d..%0d lat=%0d want=%0d", z0v[t], got[0], got[7], lat, want[t]); end
      $display("sat: z0=%0d x0=%0d x7=%0d", z0v[t], got[0], got[7]);
    end
  endtask

  task automatic test_roundtrip();
    int orig [8];
    bit bad;
    orig = '{10, 110, 20, 78, 27, 60, 54, 3};
    for (int k = 0; k < 8; k++) begin
      real ck, s;
      ck = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
      s = 0.0;
      for (int n = 0; n < 8; n++) s += orig[n] * $cos((2 * n + 1) * k * PI / 16.0);
      zv[k] = round_real(ck / 2.0 * s);
    end
    compute_expected();
    run_vector();
    for (int n = 0; n < 8; n++) begin
      int d;
      d = got[n] - orig[n];
      checks++;
      if (d > 1 || d < -1) begin errors++; $display("FAIL roundtrip_x%0d got=%0d want=%0d+-1", n, got[n], orig[n]); end
    end
    bad = 0;
    for (int n = 0; n < 8; n++) if (got[n] != expx[n]) bad = 1;
    checks++;
    if (bad) begin errors++; $display("FAIL roundtrip_model got=%0d %0d %0d %0d want=%0d %0d %0d %0d", got[0], got[1], got[2], got[3], expx[0], expx[1], expx[2], expx[3]); end
    $display("roundtrip: x=%0d %0d %0d %0d %0d %0d %0d %0d", got[0], got[1], got[2], got[3], got[4], got[5], got[6], got[7]);
  endtask

  task automatic test_random();
    bit bad;
    for (int t = 0; t < 12; t++) begin
      if (t < 9) begin
        zv[0] = int'($urandom_range(0, 1200));
        for (int k = 1; k < 8; k++) zv[k] = int'($urandom_range(0, 400)) - 200;
      end else begin
        for (int k = 0; k < 8; k++) zv[k] = int'($urandom_range(0, 32767)) - 16384;
      end
      compute_expected();
      run_vector();
      bad = (lat != LAT_EDGES);
      for (int n = 0; n < 8; n++) if (got[n] != expx[n]) bad = 1;
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL random_%0d lat=%0d got=%0d %0d %0d %0d %0d %0d %0d %0d want=%0d %0d %0d %0d %0d %0d %0d %0d", t, lat,
                 got[0], got[1], got[2], got[3], got[4], got[5], got[6], got[7],
                 expx[0], expx[1], expx[2], expx[3], expx[4], expx[5], expx[6], expx[7]);
      end
      $display("random %0d: z0=%0d z1=%0d x0=%0d x7=%0d", t, zv[0], zv[1], got[0], got[7]);
    end
  endtask

  task automatic test_handshake();
    int zfirst [8];
    int pulses;
    int ready_hi;
    bit bad;
    zv[0] = int'($urandom_range(100, 900));
    for (int k = 1; k < 8; k++) zv[k] = int'($urandom_range(0, 300)) - 150;
    zfirst = zv;
    drive_z();
    in_valid = 1'b1;
    @(posedge clk); #1;
    pulses = 0; ready_hi = 0;
    for (int i = 0; i < 8; i++) begin
      if (in_ready !== 1'b0) ready_hi++;
      scramble_z();
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    in_valid = 1'b0;
    checks++;
    if (ready_hi != 0) begin errors++; $display("FAIL handshake_ready got=%0d high cycles want=0", ready_hi); end
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL handshake_done got=%b want=1", out_valid); end
    zv = zfirst;
    compute_expected();
    bad = 0;
    for (int n = 0; n < 8; n++) if (int'(xs[n]) != expx[n]) bad = 1;
    checks++;
    if (bad) begin errors++; $display("FAIL handshake_x got=%0d %0d want=%0d %0d", x0, x7, expx[0], expx[7]); end
    repeat (10) begin @(posedge clk); #1; if (out_valid) pulses++; end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL handshake_pulses got=%0d want=1", pulses); end
    $display("handshake: pulses=%0d x0=%0d", pulses, x0);
  endtask

  task automatic test_back_to_back();
    int expa [8];
    int gap;
    int held_bad;
    bit bad;
    zv[0] = int'($urandom_range(200, 900));
    for (int k = 1; k < 8; k++) zv[k] = int'($urandom_range(0, 300)) - 150;
    compute_expected();
    expa = expx;
    run_vector();
    checks++;
    if (lat != LAT_EDGES) begin errors++; $display("FAIL b2b_first_latency got=%0d want=%0d", lat, LAT_EDGES); end
    zv[0] = int'($urandom_range(200, 900));
    for (int k = 1; k < 8; k++) zv[k] = int'($urandom_range(0, 300)) - 150;
    compute_expected();
    drive_z();
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble_z();
    gap = 1; held_bad = 0;
    while (!out_valid && gap < 30) begin
      for (int n = 0; n < 8; n++) if (int'(xs[n]) != expa[n]) held_bad++;
      @(posedge clk); #1;
      gap++;
    end
    checks++;
    if (gap != LAT_EDGES + 1) begin errors++; $display("FAIL b2b_pulse_gap got=%0d want=%0d", gap, LAT_EDGES + 1); end
    checks++;
    if (held_bad != 0) begin errors++; $display("FAIL b2b_hold got=%0d changed samples want=0", held_bad); end
    bad = 0;
    for (int n = 0; n < 8; n++) if (int'(xs[n]) != expx[n]) bad = 1;
    checks++;
    if (bad) begin errors++; $display("FAIL b2b_second_x got=%0d %0d want=%0d %0d", x0, x7, expx[0], expx[7]); end
    $display("back_to_back: gap=%0d x0=%0d", gap, x0);
  endtask

  task automatic test_reset_mid();
    int pulses;
    bit bad;
    zv[0] = 283;
    for (int k = 1; k < 8; k++) zv[k] = 0;
    run_vector();
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) zv[k] = int'($urandom_range(0, 600)) - 100;
    drive_z();
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    bad = 0;
    for (int n = 0; n < 8; n++) if (xs[n] !== 8'd0) bad = 1;
    checks++;
    if (bad) begin errors++; $display("FAIL midreset_x got=%0d %0d want=0", x0, x7); end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL midreset_flags got=%b%b want=00", out_valid, in_ready); end
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    pulses = 0;
    repeat (12) begin @(posedge clk); #1; if (out_valid) pulses++; end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL midreset_no_pulse got=%0d want=0", pulses); end
    zv[0] = int'($urandom_range(100, 900));
    for (int k = 1; k < 8; k++) zv[k] = int'($urandom_range(0, 300)) - 150;
    compute_expected();
    run_vector();
    bad = (lat != LAT_EDGES);
    for (int n = 0; n < 8; n++) if (got[n] != expx[n]) bad = 1;
    checks++;
    if (bad) begin errors++; $display("FAIL midreset_after lat=%0d got=%0d %0d want=%0d %0d", lat, got[0], got[7], expx[0], expx[7]); end
    $display("reset_mid: pulses=%0d x0=%0d", pulses, got[0]);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    build_coefs();
    test_reset();
    test_dc();
    test_saturation();
    test_roundtrip();
    test_random();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
